// File: rtl/nanotube_drop_all_pkg.sv
// nanotube_drop_all_pkg
//   Shared widths and the AXIS beat record for the drop-all stage.
//   DATA_W/KEEP_W/USER_W : default AXIS payload widths
//   PKT_CNT_W/BYTE_CNT_W : default statistics counter widths
//   ACC_W                : per-packet byte accumulator width
//   POP_W                : width of a single-beat byte count
package nanotube_drop_all_pkg;
  localparam int DATA_W     = 512;
  localparam int KEEP_W     = 64;
  localparam int USER_W     = 48;
  localparam int PKT_CNT_W  = 32;
  localparam int BYTE_CNT_W = 48;
  localparam int ACC_W      = 16;
  localparam int POP_W      = 7;

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [USER_W-1:0] tuser;
    logic              tlast;
  } axis_beat_t;
endpackage

// File: rtl/axis_keep_popcount.sv
// axis_keep_popcount
//   Combinational byte count of one AXIS beat (number of set tkeep bits).
//   i_keep  : tkeep of the beat
//   o_bytes : population count of i_keep
module axis_keep_popcount
  import nanotube_drop_all_pkg::*;
#(
  parameter int KEEP_W = nanotube_drop_all_pkg::KEEP_W
) (
  input  logic [KEEP_W-1:0] i_keep,
  output logic [POP_W-1:0]  o_bytes
);
  always_comb begin
    o_bytes = '0;
    for (int i = 0; i < KEEP_W; i++) o_bytes = o_bytes + POP_W'(i_keep[i]);
  end
endmodule

// File: rtl/nanotube_drop_all_wrapper.sv
// nanotube_drop_all_wrapper
//   XDP drop-all stage: accepts every ingress beat at full rate and discards
//   it, keeping saturating packet/byte drop counters. Egress stays idle.
//   Build option DROP_ALL_BYPASS_EN: forward beats through a 2-entry skid
//   buffer instead; the counters then count forwarded traffic.
//   ap_clk_0 / ap_rst_n_0        : clock, async active-low reset
//   port0_0_*                    : ingress AXI4-Stream
//   port1_0_*                    : egress AXI4-Stream
//   drop_pkt_count/drop_byte_count : saturating statistics
module nanotube_drop_all_wrapper #(
  parameter int DATA_W     = nanotube_drop_all_pkg::DATA_W,
  parameter int KEEP_W     = nanotube_drop_all_pkg::KEEP_W,
  parameter int USER_W     = nanotube_drop_all_pkg::USER_W,
  parameter int PKT_CNT_W  = nanotube_drop_all_pkg::PKT_CNT_W,
  parameter int BYTE_CNT_W = nanotube_drop_all_pkg::BYTE_CNT_W
) (
  input  logic                  ap_clk_0,
  input  logic                  ap_rst_n_0,
  input  logic [DATA_W-1:0]     port0_0_tdata,
  input  logic [KEEP_W-1:0]     port0_0_tkeep,
  input  logic [USER_W-1:0]     port0_0_tuser,
  input  logic                  port0_0_tlast,
  input  logic                  port0_0_tvalid,
  output logic                  port0_0_tready,
  output logic [DATA_W-1:0]     port1_0_tdata,
  output logic [KEEP_W-1:0]     port1_0_tkeep,
  output logic [USER_W-1:0]     port1_0_tuser,
  output logic                  port1_0_tlast,
  output logic                  port1_0_tvalid,
  input  logic                  port1_0_tready,
  output logic [PKT_CNT_W-1:0]  drop_pkt_count,
  output logic [BYTE_CNT_W-1:0] drop_byte_count
);
  import nanotube_drop_all_pkg::*;

  logic                  r_rdy_en;
  logic                  r_in_pkt;
  logic [ACC_W-1:0]      r_acc;
  logic [PKT_CNT_W-1:0]  r_pkt_cnt;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic [POP_W-1:0]      w_beat_bytes;
  logic [ACC_W-1:0]      w_acc_base;
  logic [ACC_W:0]        w_pkt_bytes;
  logic [BYTE_CNT_W:0]   w_byte_sum;
  logic                  w_accept;

  axis_keep_popcount #(.KEEP_W(KEEP_W)) u_pop (
    .i_keep  (port0_0_tkeep),
    .o_bytes (w_beat_bytes)
  );

  assign w_accept    = port0_0_tvalid & port0_0_tready;
  // First beat of a packet starts from zero regardless of accumulator contents.
  assign w_acc_base  = r_in_pkt ? r_acc : '0;
  assign w_pkt_bytes = {1'b0, w_acc_base} + (ACC_W+1)'(w_beat_bytes);
  // One extra bit catches the carry that triggers saturation.
  assign w_byte_sum  = {1'b0, r_byte_cnt} + (BYTE_CNT_W+1)'(w_pkt_bytes);

  // Ingress enable: low in reset, high from the first edge after release.
  always_ff @(posedge ap_clk_0 or negedge ap_rst_n_0) begin
    if (!ap_rst_n_0) r_rdy_en <= 1'b0;
    else             r_rdy_en <= 1'b1;
  end

  always_ff @(posedge ap_clk_0 or negedge ap_rst_n_0) begin
    if (!ap_rst_n_0) begin
      r_in_pkt   <= 1'b0;
      r_acc      <= '0;
      r_pkt_cnt  <= '0;
      r_byte_cnt <= '0;
    end else if (w_accept) begin
      if (port0_0_tlast) begin
        r_in_pkt   <= 1'b0;
        r_acc      <= '0;
        r_pkt_cnt  <= (&r_pkt_cnt) ? r_pkt_cnt : r_pkt_cnt + PKT_CNT_W'(1);
        r_byte_cnt <= w_byte_sum[BYTE_CNT_W] ? '1 : w_byte_sum[BYTE_CNT_W-1:0];
      end else begin
        r_in_pkt   <= 1'b1;
        // Length hint in tuser is not trusted; oversize packets wrap here.
        r_acc      <= w_pkt_bytes[ACC_W-1:0];
      end
    end
  end

  assign drop_pkt_count  = r_pkt_cnt;
  assign drop_byte_count = r_byte_cnt;

`ifdef DROP_ALL_BYPASS_EN
  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [USER_W-1:0] tuser;
    logic              tlast;
  } beat_t;

  beat_t [1:0] r_buf;
  logic        r_wr_ptr, r_rd_ptr;
  logic [1:0]  r_cnt;
  logic        w_pop;
  beat_t       w_head;

  assign port0_0_tready = r_rdy_en & (r_cnt != 2'd2);
  assign port1_0_tvalid = (r_cnt != 2'd0);
  assign w_pop          = port1_0_tvalid & port1_0_tready;
  assign w_head         = r_buf[r_rd_ptr];
  assign port1_0_tdata  = w_head.tdata;
  assign port1_0_tkeep  = w_head.tkeep;
  assign port1_0_tuser  = w_head.tuser;
  assign port1_0_tlast  = w_head.tlast;

  always_ff @(posedge ap_clk_0 or negedge ap_rst_n_0) begin
    if (!ap_rst_n_0) begin
      r_buf    <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_accept) begin
        r_buf[r_wr_ptr] <= '{port0_0_tdata, port0_0_tkeep, port0_0_tuser, port0_0_tlast};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_cnt <= r_cnt + 2'(w_accept) - 2'(w_pop);
    end
  end
`else
  logic w_unused;

  assign port0_0_tready = r_rdy_en;
  assign port1_0_tvalid = 1'b0;
  assign port1_0_tdata  = '0;
  assign port1_0_tkeep  = '0;
  assign port1_0_tuser  = '0;
  assign port1_0_tlast  = 1'b0;
  // Payload and egress ready are intentionally discarded.
  assign w_unused = ^{port0_0_tdata, port0_0_tuser, port1_0_tready};
`endif
endmodule

// File: tb/tb_nanotube_drop_all_wrapper.sv
module tb_nanotube_drop_all_wrapper;
  localparam int DW = 512;
  localparam int KW = 64;
  localparam int UW = 48;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic [UW-1:0] tuser;
  logic          tlast, tvalid, tready;
  logic [DW-1:0] o_tdata;
  logic [KW-1:0] o_tkeep;
  logic [UW-1:0] o_tuser;
  logic          o_tlast, o_tvalid;
  logic          o_tready = 1'b1;
  logic [31:0]   pkt_cnt;
  logic [47:0]   byte_cnt;
  // Second instance with a 2-bit packet counter to reach saturation quickly.
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic [UW-1:0] s_tuser;
  logic          s_tlast, s_tvalid;
  logic [1:0]    s_pkt_cnt;
  logic [47:0]   s_byte_cnt;

  always #5 clk = ~clk;

  nanotube_drop_all_wrapper dut (
    .ap_clk_0(clk), .ap_rst_n_0(rst_n),
    .port0_0_tdata(tdata), .port0_0_tkeep(tkeep), .port0_0_tuser(tuser),
    .port0_0_tlast(tlast), .port0_0_tvalid(tvalid), .port0_0_tready(tready),
    .port1_0_tdata(o_tdata), .port1_0_tkeep(o_tkeep), .port1_0_tuser(o_tuser),
    .port1_0_tlast(o_tlast), .port1_0_tvalid(o_tvalid), .port1_0_tready(o_tready),
    .drop_pkt_count(pkt_cnt), .drop_byte_count(byte_cnt)
  );

  nanotube_drop_all_wrapper #(.PKT_CNT_W(2)) dut_sat (
    .ap_clk_0(clk), .ap_rst_n_0(rst_n),
    .port0_0_tdata(tdata), .port0_0_tkeep(tkeep), .port0_0_tuser(tuser),
    .port0_0_tlast(tlast), .port0_0_tvalid(tvalid), .port0_0_tready(s_tready),
    .port1_0_tdata(s_tdata), .port1_0_tkeep(s_tkeep), .port1_0_tuser(s_tuser),
    .port1_0_tlast(s_tlast), .port1_0_tvalid(s_tvalid), .port1_0_tready(o_tready),
    .drop_pkt_count(s_pkt_cnt), .drop_byte_count(s_byte_cnt)
  );

  int     n_cmp = 0, n_fail = 0;
  longint exp_pkts = 0, exp_bytes = 0, cur_bytes = 0;
  int     exp_sat = 0;
  bit     chk_next = 1'b0;

`ifdef DROP_ALL_BYPASS_EN
  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } bt_t;
  bt_t exp_q[$];
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] keep_of(input int n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  task automatic check_counts();
    check("pkt_count", pkt_cnt, 64'(exp_pkts));
    check("byte_count", byte_cnt, 64'(exp_bytes));
    check("sat_pkt_count", s_pkt_cnt, 64'(exp_sat));
  endtask

  // One beat: driven after a falling edge, held until the DUT takes it.
  task automatic beat(input logic [63:0] keep, input logic last);
    int guard;
    @(negedge clk);
    if (chk_next) begin check_counts(); chk_next = 1'b0; end
    tvalid = 1'b1; tkeep = keep; tlast = last;
    tdata  = {16{$urandom()}};
    tuser  = {16'($urandom()), $urandom()};
    #1;
    guard = 0;
    while (tready !== 1'b1 && guard < 100) begin @(negedge clk); #1; guard++; end
    if (guard >= 100) check("ingress_ready_timeout", 64'(tready), 64'd1);
`ifdef DROP_ALL_BYPASS_EN
    exp_q.push_back('{tdata, tkeep, tuser, last});
`else
    check("ingress_ready", 64'(tready), 64'd1);
    check("egress_idle", {o_tvalid, o_tlast, |o_tdata, |o_tkeep, |o_tuser}, 64'd0);
`endif
    cur_bytes += $countones(keep);
    if (last) begin
      exp_pkts++;
      exp_bytes += cur_bytes;
      cur_bytes = 0;
      if (exp_sat < 3) exp_sat++;
      chk_next = 1'b1;
    end
  endtask

  // Idle cycle with garbage on the bus; tvalid low must leave state alone.
  task automatic idle();
    @(negedge clk);
    if (chk_next) begin check_counts(); chk_next = 1'b0; end
    tvalid = 1'b0; tlast = 1'b1; tkeep = keep_of($urandom_range(0, 64));
  endtask

`ifdef DROP_ALL_BYPASS_EN
  initial begin
    bt_t e;
    forever begin
      @(negedge clk);
      o_tready = 1'($urandom_range(0, 1));
      #1;
      if (rst_n && o_tvalid && o_tready) begin
        if (exp_q.size() == 0) check("egress_unexpected", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("egress_tkeep", o_tkeep, e.k);
          check("egress_tuser", 64'(o_tuser), 64'(e.u));
          check("egress_tlast", 64'(o_tlast), 64'(e.l));
          check("egress_tdata_eq", 64'(o_tdata === e.d), 64'd1);
        end
      end
    end
  end
`else
  initial forever begin
    @(negedge clk);
    o_tready = 1'($urandom_range(0, 1));
  end
`endif

  initial begin
    rst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; tkeep = '0; tdata = '0; tuser = '0;
    #2;
    check("rst_tready", 64'(tready), 64'd0);
    check("rst_egress", {o_tvalid, o_tlast, |o_tdata, |o_tkeep, |o_tuser}, 64'd0);
    check_counts();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("tready_before_edge", 64'(tready), 64'd0);
    @(negedge clk);
    check("tready_after_release", 64'(tready), 64'd1);

    // Two back-to-back packets: 64+35 then 64+7 bytes.
    beat('1, 1'b0);
    beat(64'h0000_0007_FFFF_FFFF, 1'b1);
    beat('1, 1'b0);
    beat(64'h7F, 1'b1);
    idle();
    check("bytes_after_two", byte_cnt, 64'd170);
    // Single-beat packet and an empty-keep last beat.
    beat(64'h1, 1'b1);
    beat(64'h0, 1'b1);
    repeat (3) idle();

    // Random packets of 1-4 beats with occasional gaps.
    repeat (12) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++)
        beat(keep_of((b == nb - 1) ? $urandom_range(0, 64) : 64), 1'(b == nb - 1));
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    // Reset in the middle of a packet drops the partial packet.
    beat('1, 1'b0);
    @(negedge clk);
    tvalid = 1'b0; rst_n = 1'b0;
    exp_pkts = 0; exp_bytes = 0; cur_bytes = 0; exp_sat = 0;
`ifdef DROP_ALL_BYPASS_EN
    exp_q.delete();
`endif
    #1;
    check("midrst_tready", 64'(tready), 64'd0);
    check_counts();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat('1, 1'b0);
    beat(keep_of(10), 1'b1);
    idle();
    check("bytes_after_midrst", byte_cnt, 64'd74);

    // Push the 2-bit counter instance to and past all-ones.
    repeat (4) beat(keep_of($urandom_range(1, 64)), 1'b1);
    idle();
    check("sat_holds_ones", s_pkt_cnt, 64'd3);

`ifdef DROP_ALL_BYPASS_EN
    begin
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin @(negedge clk); guard++; end
      check("egress_drained", 64'(exp_q.size()), 64'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
